// File: rtl/out_port_fifo.sv
// out_port_fifo: capture buffer behind the write-back OUT port.
// The block enqueues WD whenever the WB stage asserts out. A consumer drains
// entries over a valid/ready handshake. Writes that arrive while the buffer is
// full and nothing is leaving are dropped and counted; the pipeline never stalls.
module out_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_ready,
  input  logic          clr_ovf,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          overflow,
  output logic [DW-1:0] drop_cnt
);

  // Occupancy thresholds expressed at count width
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AFULL = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DCNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DCNT_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DCNT_MAX  = {DW{1'b1}};

  // Pointers wrap for free only when DEPTH is exactly 2**AW
  if (DEPTH != (1 << AW) || DEPTH < 2) begin : g_bad_depth
    $error("out_port_fifo: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  // Storage and state
  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          empty_r;
  logic          full_r;
  logic          afull_r;
  logic          valid_r;
  logic          overflow_r;
  logic [DW-1:0] drop_cnt_r;

  // Next-state signals
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [AW:0]   count_nxt_s;
  logic          overflow_nxt_s;
  logic [DW-1:0] drop_cnt_nxt_s;
  logic [W-1:0]  head_s;

  // Handshake decode: a full buffer still accepts a write when the head leaves
  always_comb begin
    pop_s  = valid_r & rd_ready;
    push_s = wr_en & (~full_r | pop_s);
    drop_s = wr_en & full_r & ~pop_s;
  end

  // Occupancy update from the push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      2'b11:   count_nxt_s = count_r;
      2'b00:   count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Overflow bookkeeping: a drop in the same cycle as a clear takes priority
  always_comb begin
    overflow_nxt_s = overflow_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
      if (clr_ovf) begin
        drop_cnt_nxt_s = DCNT_ONE;
      end else if (drop_cnt_r != DCNT_MAX) begin
        drop_cnt_nxt_s = drop_cnt_r + DCNT_ONE;
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
    end else if (clr_ovf) begin
      overflow_nxt_s = 1'b0;
      drop_cnt_nxt_s = DCNT_ZERO;
    end else begin
      overflow_nxt_s = overflow_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // Data array write port; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and flags; flags are registered from next count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= CNT_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      afull_r    <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      valid_r <= (count_nxt_s != CNT_ZERO);
      full_r  <= (count_nxt_s == CNT_FULL);
      afull_r <= (count_nxt_s >= CNT_AFULL);
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= DCNT_ZERO;
    end else begin
      overflow_r <= overflow_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  // Head entry is presented only while valid, otherwise forced to zero
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (valid_r) begin
      rd_data = head_s;
    end else begin
      rd_data = {W{1'b0}};
    end
  end

  assign rd_valid    = valid_r;
  assign count       = count_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = afull_r;
  assign overflow    = overflow_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo using a queue scoreboard.
module tb_out_port_fifo;

  localparam int W = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_ready;
  logic          clr_ovf;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic [DW-1:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] sb_q[$];
  logic         m_ovf;
  logic [DW-1:0] m_dcnt;

  out_port_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard state
  task automatic check_all(input string tag);
    int n;
    logic [W-1:0] head;
    n = sb_q.size();
    head = (n > 0) ? sb_q[0] : 16'h0000;
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 1));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(head));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dcnt));
  endtask

  // One clock of stimulus: drive at negedge, score the pop, update model, check after edge
  task automatic step(input string tag, input logic we, input logic [W-1:0] d,
                      input logic rdy, input logic clr);
    logic pop;
    logic was_full;
    logic [W-1:0] exp;
    @(negedge clk);
    wr_en    = we;
    wr_data  = we ? d : W'($urandom);
    rd_ready = rdy;
    clr_ovf  = clr;
    #1;
    was_full = (sb_q.size() == DEPTH);
    pop = rdy && (sb_q.size() > 0);
    if (pop) begin
      exp = sb_q.pop_front();
      check({tag, ".pop_data"}, 32'(rd_data), 32'(exp));
    end
    if (we && (!was_full || pop)) begin
      sb_q.push_back(d);
    end
    if (we && was_full && !pop) begin
      m_ovf = 1'b1;
      if (clr) m_dcnt = 8'h01;
      else if (m_dcnt != 8'hFF) m_dcnt = m_dcnt + 8'h01;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dcnt = 8'h00;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; rd_ready = 1'b0; clr_ovf = 1'b0;
    m_ovf = 1'b0; m_dcnt = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Three pushes without draining
    step("push1", 1'b1, 16'h1111, 1'b0, 1'b0);
    step("push2", 1'b1, 16'h2222, 1'b0, 1'b0);
    step("push3", 1'b1, 16'h3333, 1'b0, 1'b0);
    check("three.count", 32'(count), 32'd3);
    check("three.head", 32'(rd_data), 32'h1111);

    // Drain them in order
    for (int i = 0; i < 3; i++) step("drain3", 1'b0, 16'h0000, 1'b1, 1'b0);
    check("drained.rd_data", 32'(rd_data), 32'h0000);

    // Fill to full, watching almost_full and full thresholds
    for (int i = 0; i < 8; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'd1);
    // Two drops
    step("drop_dead", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    step("drop_beef", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("drops.drop_cnt", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) step("drain8", 1'b0, 16'h0000, 1'b1, 1'b0);
    // rd_ready while empty: no underflow
    step("rdy_empty", 1'b0, 16'h0000, 1'b1, 1'b0);
    step("rdy_empty2", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Refill, clear overflow, then write+pop while full
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 16'h0100 + W'(i), 1'b0, 1'b0);
    step("clr", 1'b0, 16'h0000, 1'b0, 1'b1);
    step("full_wr_pop", 1'b1, 16'hAAAA, 1'b1, 1'b0);
    check("full_wr_pop.count", 32'(count), 32'd8);
    check("full_wr_pop.overflow", 32'(overflow), 32'd0);

    // Five drops, then a drop concurrent with clear
    for (int i = 0; i < 5; i++) step("drop5", 1'b1, 16'h5555, 1'b0, 1'b0);
    check("drop5.drop_cnt", 32'(drop_cnt), 32'd5);
    step("drop_clr", 1'b1, 16'h6666, 1'b0, 1'b1);
    check("drop_clr.drop_cnt", 32'(drop_cnt), 32'd1);
    // Saturation
    for (int i = 0; i < 256; i++) step("sat", 1'b1, W'($urandom), 1'b0, 1'b0);
    check("sat.drop_cnt", 32'(drop_cnt), 32'h000000FF);

    // Down to five entries, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) step("to5", 1'b0, 16'h0000, 1'b1, 1'b0);
    check("to5.count", 32'(count), 32'd5);
    @(posedge clk);
    #3;
    wr_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    rst = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_dcnt = 8'h00;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;

    step("post_rst", 1'b1, 16'h0042, 1'b0, 1'b0);
    check("post_rst.rd_data", 32'(rd_data), 32'h0042);

    // Mixed traffic across pointer wrap
    for (int i = 0; i < 20; i++)
      step("mixed", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 10; i++) step("final_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
Name: out_port_fifo

Overview:
- Capture buffer directly downstream of the processor's write-back output port.
- Each cycle the WB stage asserts its out signal, the block enqueues the 16-bit WD value.
- An external consumer drains the buffer over a valid/ready handshake, so bursts of OUT instructions are not lost while the consumer is slow.
- Overflow is reported with a sticky flag and a saturating drop counter. The block never stalls the pipeline.

Parameters:
W, 16, data width (matches processor word)
DEPTH, 8, number of entries; must be a power of two, >= 2
AW, 3, pointer width = log2(DEPTH)
DW, 8, drop-counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  WB out signal; enqueue request
wr_data  in  W  WD from write-back; may be Z/X when wr_en=0, must then be ignored
rd_ready  in  1  consumer can accept head entry
clr_ovf  in  1  clears overflow and drop_cnt
rd_valid  out  1  head entry available (= !empty)
rd_data  out  W  head entry; 0 when empty
count  out  AW+1  current occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=DEPTH-1
overflow  out  1  sticky: a write was dropped
drop_cnt  out  DW  number of dropped writes, saturating at all-ones

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0.
  - Outputs: empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately. The first edge after release behaves as from empty.
- Definitions: push = wr_en & (!full | pop); pop = rd_valid & rd_ready.
- Push writes mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - both or neither: unchanged.
- Full with simultaneous pop: the write is accepted, count stays DEPTH, no overflow.
- Empty with simultaneous write: no pop is possible because rd_valid=0. The entry becomes visible one cycle later; there is no write-to-read bypass.
- Latency: a value pushed at edge N appears on rd_data/rd_valid after edge N, provided no older entries remain.
- rd_data = mem[rd_ptr] combinationally when !empty, else 0.
- Flags empty, full, almost_full, rd_valid are registered or derived from the registered count. They are glitch-free relative to clk.
- Drop condition: wr_en & full & !pop.
  - wr_data is discarded and no pointer moves.
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, unless it is all-ones, in which case it holds.
- clr_ovf=1 sets overflow <= 0 and drop_cnt <= 0.
  - If a drop occurs in the same cycle as clr_ovf, the drop wins: overflow=1, drop_cnt=1.
- rd_ready while empty has no effect: no pointer movement and no underflow.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0 and ordering is preserved (FIFO order strictly).
- No state machine beyond occupancy; the block has no internal stall or back-pressure to the processor.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles with rd_ready=0 -> count=3, rd_valid=1, rd_data=0x1111, empty=0, almost_full=0.
- Raise rd_ready for 3 cycles -> rd_data sequence 0x1111, 0x2222, 0x3333. Then empty=1, rd_data=0, count=0.
- Push 8 words 0x0000..0x0007 with rd_ready=0 -> count=7 gives almost_full=1; count=8 gives full=1.
  - Push 0xDEAD and 0xBEEF -> both dropped, overflow=1, drop_cnt=2, count=8.
  - Drain -> 0x0000..0x0007 in order.
- Full FIFO, wr_en=1 with data 0xAAAA and rd_ready=1 in the same cycle -> head popped, 0xAAAA accepted, count stays 8, overflow unchanged (0 after clr_ovf).
- Assert clr_ovf in the same cycle as a drop while drop_cnt=5 -> overflow=1, drop_cnt=1.
  - Then 256 further drops -> drop_cnt saturates at 0xFF.
- Fill to 5 entries, pull rst low mid-cycle (asynchronously) -> count=0, empty=1, rd_data=0 immediately.
  - After release, push 0x0042 -> rd_data=0x0042 next cycle, wr_ptr/rd_ptr wrap checked after 20 mixed push/pop cycles against a reference queue model.
